discr_scaler_counters: RTL and testbench
========================================

DISCR_SCALER_COUNTERS -- requirements
Module: discr_scaler_counters

Interface
REQ-001 The block SHALL take parameter N_CH, default 8, as the number of discriminator channels.
REQ-002 The block SHALL take parameter CNT_W, default 24, as the width of each per-channel count.
REQ-003 clk  in  1  single system clock; all logic is in this one clock domain.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  counting enable; a high level starts and sustains back-to-back windows.
REQ-006 gate_len  in  32  window length in clk cycles, sampled only at each window start.
REQ-007 bits_in  in  N_CH  inhibited discriminator pulses from the upstream inhibit generator (its bits_out).
REQ-008 rd_sel  in  clog2(N_CH)  selects the latched channel to read.
REQ-009 rd_data  out  CNT_W  latched count of channel rd_sel, registered.
REQ-010 rd_ovf  out  1  saturation flag of channel rd_sel, registered.
REQ-011 win_done  out  1  one-cycle pulse; the latched counts have just been updated.
REQ-012 win_cnt  out  16  number of completed windows, wrapping.
REQ-013 busy  out  1  high while in state COUNT.

Function
REQ-014 The FSM SHALL have two states, IDLE and COUNT.
REQ-015 In IDLE, the live counters SHALL be held at 0.
REQ-016 IDLE SHALL go to COUNT on the edge where en=1 and gate_len!=0, loading timer=gate_len-1.
REQ-017 gate_len==0 SHALL keep the block in IDLE regardless of en.
REQ-018 In COUNT, each cycle, counter[i] SHALL add bits_in[i], saturating at 2^CNT_W-1.
REQ-019 On any increment attempted while counter[i] is at its maximum, the block SHALL set live ovf[i].
REQ-020 In COUNT, the timer SHALL decrement each cycle while nonzero.
REQ-021 The terminal cycle SHALL be the COUNT cycle with timer==0.
REQ-022 On the terminal cycle, shadow[i] SHALL load the saturated value of counter[i]+bits_in[i], so a terminal-cycle pulse counts in the ending window.
REQ-023 On the terminal cycle, the shadow ovf flags SHALL load likewise, and the live counters and flags SHALL clear.
REQ-024 On the terminal cycle with en=1 and gate_len!=0, the FSM SHALL stay in COUNT and reload timer=gate_len-1, so windows are exactly gate_len cycles with no dead time.
REQ-025 On the terminal cycle otherwise, the FSM SHALL go to IDLE.
REQ-026 win_done SHALL be high for exactly the one cycle after the terminal cycle, the first cycle in which the new shadow values are visible.
REQ-027 win_cnt SHALL increment with each win_done and wrap from 0xFFFF to 0.
REQ-028 en=0 in any non-terminal COUNT cycle SHALL abort the window: go to IDLE, clear the live counters, leave the shadows unchanged and issue no win_done.
REQ-029 A gate_len change during a window SHALL take effect only at the next reload.
REQ-030 rd_data and rd_ovf SHALL reflect shadow[rd_sel] with one cycle of latency.
REQ-031 If the shadow is updated in the same cycle rd_sel is presented, the registered read SHALL return the new value one cycle after win_done.

Reset
REQ-032 While rst=0, all state SHALL asynchronously reset: FSM=IDLE, timer=0, counters=0, shadows=0, all ovf flags=0.
REQ-033 While rst=0, all outputs SHALL be 0: rd_data, rd_ovf, win_done, win_cnt and busy.
REQ-034 Assertion of rst mid-window SHALL discard the partial window without issuing win_done.

Structure
REQ-035 N_CH, CNT_W and the FSM state encodings SHALL live in the shared discr_scaler package (header), which is also used by the inhibit generator.
REQ-036 A sub-module, scaler_channel_counter, SHALL hold one saturating counter, its ovf flag and its shadow register, and SHALL be instantiated N_CH times.
REQ-037 The FSM, timer, win_cnt and read mux SHALL live in the top module.

Verification
REQ-038 en=1, gate_len=10, pulse on ch0 at window cycle 3 and on ch7 at cycles 2 and 5 -> win_done 10 cycles after start; shadow ch0=1, ch7=2, others 0; win_cnt=1.
REQ-039 gate_len=4, ch2 pulses on terminal cycle and next cycle -> window 1 ch2=1, window 2 ch2=1, win_done spaced exactly 4 cycles.
REQ-040 CNT_W=8, bits_in[3] held high, gate_len=300 -> ch3=255, rd_ovf=1 for rd_sel=3; ch4 ovf=0.
REQ-041 en dropped at window cycle 5 of 10 -> no win_done, busy low next cycle, shadows keep prior values, win_cnt unchanged.
REQ-042 gate_len=0 with en=1 -> busy stays 0; gate_len=1 with bits_in=8'hAA every cycle -> win_done every cycle, odd channels read 1, even channels 0.
REQ-043 rst pulled low at window cycle 6 -> all outputs 0 immediately; after release and en=1 the next window counts from 0.

Source files
------------

// File: rtl/discr_scaler_counters_pkg.sv
// Shared discriminator-scaler definitions: channel/count defaults, fixed port widths,
// FSM state encoding and the read-select width helper.
package discr_scaler_counters_pkg;

  localparam int unsigned N_CH_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned GATE_W    = 32;
  localparam int unsigned WCNT_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // A single-channel build still needs a one-bit select.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/discr_scaler_counters_if.sv
// Control, pulse-input and readout signals of the discriminator scaler.
// The master modport drives the controls; the slave modport is the scaler.
interface discr_scaler_counters_if
  import discr_scaler_counters_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  localparam int unsigned SEL_W = sel_w(N_CH);

  logic              en;
  logic [GATE_W-1:0] gate_len;
  logic [N_CH-1:0]   bits_in;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_ovf;
  logic              win_done;
  logic [WCNT_W-1:0] win_cnt;
  logic              busy;

  modport master (
    output en, gate_len, bits_in, rd_sel,
    input  rd_data, rd_ovf, win_done, win_cnt, busy
  );

  modport slave (
    input  en, gate_len, bits_in, rd_sel,
    output rd_data, rd_ovf, win_done, win_cnt, busy
  );

endinterface

// File: rtl/scaler_channel_counter.sv
// One scaler channel: live saturating counter with sticky overflow flag, and the
// shadow copy that captures the closing window on the terminal cycle.
module scaler_channel_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_i,
  input  logic             latch_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             shadow_ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d, sum_s;
  logic             ovf_q, ovf_d, shadow_ovf_q, shadow_ovf_d, ovf_s;

  // The latch path uses the saturated sum so a terminal-cycle pulse lands in the ending window.
  always_comb begin
    sum_s        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(bit_i);
    ovf_s        = ovf_q | ((cnt_q == CNT_MAX) & bit_i);
    cnt_d        = {CNT_W{1'b0}};
    ovf_d        = 1'b0;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    if (latch_i) begin
      shadow_d     = sum_s;
      shadow_ovf_d = ovf_s;
    end else if (acc_i) begin
      cnt_d = sum_s;
      ovf_d = ovf_s;
    end else begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end
  end

  // Live and shadow state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= {CNT_W{1'b0}};
      ovf_q        <= 1'b0;
      shadow_q     <= {CNT_W{1'b0}};
      shadow_ovf_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
    end
  end

  assign shadow_o     = shadow_q;
  assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/discr_scaler_counters.sv
// Gated multi-channel scaler: counts inhibited discriminator pulses over back-to-back
// windows of gate_len cycles, latches each window and serves a registered readout.
module discr_scaler_counters
  import discr_scaler_counters_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  discr_scaler_counters_if.slave bus
);

  localparam int unsigned SEL_W  = sel_w(N_CH);
  localparam int unsigned N_SLOT = 1 << SEL_W;

  state_e            state_q, state_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic              latch_s, acc_s;
  logic              win_done_q;
  logic [WCNT_W-1:0] win_cnt_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_ovf_q;

  logic [CNT_W-1:0]  shadow_s     [N_SLOT];
  logic              shadow_ovf_s [N_SLOT];

  // Unused select codes beyond N_CH read back as zero.
  for (genvar i = 0; i < N_SLOT; i++) begin : g_ch
    if (i < N_CH) begin : g_cnt
      scaler_channel_counter #(.CNT_W(CNT_W)) u_ch (
        .clk          (clk),
        .rst          (rst),
        .acc_i        (acc_s),
        .latch_i      (latch_s),
        .bit_i        (bus.bits_in[i]),
        .shadow_o     (shadow_s[i]),
        .shadow_ovf_o (shadow_ovf_s[i])
      );
    end else begin : g_pad
      assign shadow_s[i]     = {CNT_W{1'b0}};
      assign shadow_ovf_s[i] = 1'b0;
    end
  end

  // Window FSM: the terminal cycle latches and either reloads (no dead time) or idles.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    latch_s = 1'b0;
    acc_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.gate_len != 32'd0)) begin
          state_d = ST_COUNT;
          timer_d = bus.gate_len - 32'd1;
        end else begin
          state_d = ST_IDLE;
          timer_d = {GATE_W{1'b0}};
        end
      end
      ST_COUNT: begin
        if (timer_q == 32'd0) begin
          latch_s = 1'b1;
          if (bus.en && (bus.gate_len != 32'd0)) begin
            state_d = ST_COUNT;
            timer_d = bus.gate_len - 32'd1;
          end else begin
            state_d = ST_IDLE;
            timer_d = {GATE_W{1'b0}};
          end
        end else if (!bus.en) begin
          state_d = ST_IDLE;
          timer_d = {GATE_W{1'b0}};
        end else begin
          acc_s   = 1'b1;
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {GATE_W{1'b0}};
      end
    endcase
  end

  // Control state, window bookkeeping and registered readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= {GATE_W{1'b0}};
      win_done_q <= 1'b0;
      win_cnt_q  <= {WCNT_W{1'b0}};
      rd_data_q  <= {CNT_W{1'b0}};
      rd_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      win_done_q <= latch_s;
      win_cnt_q  <= win_cnt_q + {{(WCNT_W-1){1'b0}}, latch_s};
      rd_data_q  <= shadow_s[bus.rd_sel];
      rd_ovf_q   <= shadow_ovf_s[bus.rd_sel];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ovf   = rd_ovf_q;
  assign bus.win_done = win_done_q;
  assign bus.win_cnt  = win_cnt_q;
  assign bus.busy     = (state_q == ST_COUNT);

endmodule

// File: tb/tb_discr_scaler_counters.sv
// Self-checking bench for discr_scaler_counters (8 channels, 8-bit counts): a vector
// table, directed window sequences and random traffic against a window-sum model.
module tb_discr_scaler_counters;

  localparam int unsigned NC   = 8;
  localparam int unsigned CMAX = 255;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  discr_scaler_counters_if #(.N_CH(NC), .CNT_W(8)) bus ();

  discr_scaler_counters #(.N_CH(NC), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-window unbounded sums, saturated only when a window closes.
  int unsigned m_sum    [NC];
  int unsigned m_shadow [NC];
  bit          m_ovf    [NC];
  bit          m_active;
  int unsigned m_left;
  int unsigned m_wcnt;
  bit          m_done;
  int unsigned m_rd;
  bit          m_rdovf;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_sum[i] = 0; m_shadow[i] = 0; m_ovf[i] = 1'b0;
    end
    m_active = 1'b0; m_left = 0; m_wcnt = 0; m_done = 1'b0; m_rd = 0; m_rdovf = 1'b0;
  endtask

  task automatic model_edge(input bit en, input int unsigned gl, input logic [7:0] bits,
                            input int unsigned sel);
    m_rd    = m_shadow[sel];
    m_rdovf = m_ovf[sel];
    m_done  = 1'b0;
    if (!m_active) begin
      if (en && gl != 0) begin
        m_active = 1'b1;
        m_left   = gl;
      end
    end else begin
      for (int i = 0; i < NC; i++) m_sum[i] += bits[i];
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < NC; i++) begin
          m_shadow[i] = (m_sum[i] > CMAX) ? CMAX : m_sum[i];
          m_ovf[i]    = (m_sum[i] > CMAX);
          m_sum[i]    = 0;
        end
        m_done = 1'b1;
        m_wcnt = (m_wcnt + 1) % 65536;
        if (en && gl != 0) m_left = gl;
        else m_active = 1'b0;
      end else if (!en) begin
        m_active = 1'b0;
        for (int i = 0; i < NC; i++) m_sum[i] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, clock, then compare every output with the model.
  task automatic step(input bit en, input int unsigned gl, input logic [7:0] bits,
                      input int unsigned sel);
    bus.en       = en;
    bus.gate_len = gl;
    bus.bits_in  = bits;
    bus.rd_sel   = 3'(sel);
    model_edge(en, gl, bits, sel);
    @(posedge clk);
    #1;
    chk("win_done", {31'd0, bus.win_done}, {31'd0, m_done});
    chk("busy",     {31'd0, bus.busy},     {31'd0, m_active});
    chk("win_cnt",  {16'd0, bus.win_cnt},  m_wcnt);
    chk("rd_data",  {24'd0, bus.rd_data},  m_rd);
    chk("rd_ovf",   {31'd0, bus.rd_ovf},   {31'd0, m_rdovf});
  endtask

  typedef struct {
    bit          en;
    int unsigned gl;
    logic [7:0]  bits;
    int unsigned sel;
    bit          done;
    bit          busy;
    int unsigned wc;
    int unsigned rd;
  } vec_t;

  vec_t tv [9];

  initial begin
    tv[0] = '{1'b1, 0, 8'hAA, 0, 1'b0, 1'b0, 0, 0};
    tv[1] = '{1'b1, 0, 8'hAA, 0, 1'b0, 1'b0, 0, 0};
    tv[2] = '{1'b1, 1, 8'hAA, 1, 1'b0, 1'b1, 0, 0};
    tv[3] = '{1'b1, 1, 8'hAA, 1, 1'b1, 1'b1, 1, 0};
    tv[4] = '{1'b1, 1, 8'hAA, 1, 1'b1, 1'b1, 2, 1};
    tv[5] = '{1'b1, 1, 8'hAA, 2, 1'b1, 1'b1, 3, 0};
    tv[6] = '{1'b1, 1, 8'hAA, 7, 1'b1, 1'b1, 4, 1};
    tv[7] = '{1'b0, 1, 8'hAA, 6, 1'b1, 1'b0, 5, 0};
    tv[8] = '{1'b0, 1, 8'hAA, 5, 1'b0, 1'b0, 5, 1};

    rst = 1'b1;
    bus.en = 1'b0; bus.gate_len = 32'd0; bus.bits_in = 8'd0; bus.rd_sel = 3'd0;
    model_reset();
    #1 rst = 1'b0;
    #11;
    chk("reset_rd_data",  {24'd0, bus.rd_data},  32'd0);
    chk("reset_rd_ovf",   {31'd0, bus.rd_ovf},   32'd0);
    chk("reset_win_done", {31'd0, bus.win_done}, 32'd0);
    chk("reset_win_cnt",  {16'd0, bus.win_cnt},  32'd0);
    chk("reset_busy",     {31'd0, bus.busy},     32'd0);
    #10 rst = 1'b1;

    // gate_len 0 holds IDLE; gate_len 1 closes a window every cycle.
    for (int k = 0; k < 9; k++) begin
      step(tv[k].en, tv[k].gl, tv[k].bits, tv[k].sel);
      chk("tv_done", {31'd0, bus.win_done}, {31'd0, tv[k].done});
      chk("tv_busy", {31'd0, bus.busy},     {31'd0, tv[k].busy});
      chk("tv_wcnt", {16'd0, bus.win_cnt},  tv[k].wc);
      chk("tv_rd",   {24'd0, bus.rd_data},  tv[k].rd);
    end

    // Ten-cycle window with pulses on ch0 and ch7.
    step(1'b1, 10, 8'h00, 0);
    for (int c = 1; c <= 10; c++) begin
      step(c < 10, 10, ((c == 3) ? 8'h01 : 8'h00) | ((c == 2 || c == 5) ? 8'h80 : 8'h00), 0);
      chk("w10_done", {31'd0, bus.win_done}, (c == 10) ? 32'd1 : 32'd0);
    end
    chk("w10_wcnt", {16'd0, bus.win_cnt}, 32'd6);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 10, 8'h00, i);
      chk("w10_rd", {24'd0, bus.rd_data}, (i == 0) ? 32'd1 : ((i == 7) ? 32'd2 : 32'd0));
    end

    // Terminal-cycle pulse counts in the ending window; next-cycle pulse in the new one.
    step(1'b1, 4, 8'h00, 2);
    for (int c = 1; c <= 8; c++) begin
      step(c < 8, 4, (c == 4 || c == 5) ? 8'h04 : 8'h00, 2);
      chk("w4_done", {31'd0, bus.win_done}, (c == 4 || c == 8) ? 32'd1 : 32'd0);
      if (c == 5) chk("w4_rd_win1", {24'd0, bus.rd_data}, 32'd1);
    end
    step(1'b0, 4, 8'h00, 2);
    chk("w4_rd_win2", {24'd0, bus.rd_data}, 32'd1);
    chk("w4_wcnt", {16'd0, bus.win_cnt}, 32'd8);

    // Saturation: ch3 held high for 300 cycles.
    step(1'b1, 300, 8'h08, 3);
    for (int c = 1; c <= 300; c++) step(c < 300, 300, 8'h08, 3);
    chk("sat_done", {31'd0, bus.win_done}, 32'd1);
    step(1'b0, 300, 8'h00, 3);
    chk("sat_rd3", {24'd0, bus.rd_data}, 32'd255);
    chk("sat_ovf3", {31'd0, bus.rd_ovf}, 32'd1);
    step(1'b0, 300, 8'h00, 4);
    chk("sat_ovf4", {31'd0, bus.rd_ovf}, 32'd0);

    // Abort at window cycle 5 of 10.
    step(1'b1, 10, 8'h02, 3);
    for (int c = 1; c <= 4; c++) step(1'b1, 10, 8'h02, 3);
    step(1'b0, 10, 8'h02, 3);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.win_done}, 32'd0);
    chk("abort_wcnt", {16'd0, bus.win_cnt}, 32'd9);
    step(1'b0, 10, 8'h00, 3);
    chk("abort_keep", {24'd0, bus.rd_data}, 32'd255);

    // Reset in the middle of a window.
    step(1'b1, 10, 8'h00, 1);
    for (int c = 1; c <= 5; c++) step(1'b1, 10, 8'h02, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_rd_data",  {24'd0, bus.rd_data},  32'd0);
    chk("rst_rd_ovf",   {31'd0, bus.rd_ovf},   32'd0);
    chk("rst_win_done", {31'd0, bus.win_done}, 32'd0);
    chk("rst_win_cnt",  {16'd0, bus.win_cnt},  32'd0);
    chk("rst_busy",     {31'd0, bus.busy},     32'd0);
    model_reset();
    bus.en = 1'b0;
    @(posedge clk);
    #4 rst = 1'b1;
    step(1'b1, 3, 8'h02, 1);
    for (int c = 1; c <= 3; c++) step(c < 3, 3, 8'h02, 1);
    chk("rst_new_done", {31'd0, bus.win_done}, 32'd1);
    chk("rst_new_wcnt", {16'd0, bus.win_cnt}, 32'd1);
    step(1'b0, 3, 8'h00, 1);
    chk("rst_new_rd", {24'd0, bus.rd_data}, 32'd3);

    // Random traffic, including mid-window gate_len changes and gate_len 0 reloads.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 6), 8'($urandom),
           $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
